// File: rtl/audio_pkg.sv
// audio_pkg: shared types and defaults for the lab3 record/playback controller.
//   state_t  - 3-bit controller state encoding (driven out on o_state)
//   cmd_t    - command-pulse bundle {start, pause, stop} for one engine
//   ADDR_W_DEF / DATA_W_DEF / MAX_ADDR_DEF - default SRAM geometry
// Optional feature macro used by audio_ctrl: AUDIO_CTRL_LOOP_PLAY_EN.
package audio_pkg;

    localparam int unsigned ADDR_W_DEF   = 20;
    localparam int unsigned DATA_W_DEF   = 16;
    localparam logic [19:0] MAX_ADDR_DEF = 20'hFFFFF;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StRec       = 3'd1,
        StRecPause  = 3'd2,
        StPlay      = 3'd3,
        StPlayPause = 3'd4
    } state_t;

    typedef struct packed {
        logic start;
        logic pause;
        logic stop;
    } cmd_t;

endpackage

// File: rtl/audio_sram_mux.sv
// audio_sram_mux: combinational SRAM port mux selected by the controller state.
// Ports:
//   i_state                      - registered controller state
//   i_rec_addr/i_rec_data/i_rec_valid - recorder write request
//   i_play_addr                  - DSP read address
//   o_sram_addr/o_sram_we_n/o_sram_dq_out/o_sram_dq_oe - SRAM pin controls
// Macro: none (AUDIO_CTRL_LOOP_PLAY_EN does not affect this block).
module audio_sram_mux
    import audio_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  state_t            i_state,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [DATA_W-1:0] i_rec_data,
    input  logic              i_rec_valid,
    input  logic [ADDR_W-1:0] i_play_addr,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we_n,
    output logic [DATA_W-1:0] o_sram_dq_out,
    output logic              o_sram_dq_oe
);

    always_comb begin
        o_sram_addr   = '0;
        o_sram_we_n   = 1'b1;
        o_sram_dq_out = '0;
        o_sram_dq_oe  = 1'b0;
        case (i_state)
            StRec: begin
                o_sram_addr   = i_rec_addr;
                o_sram_dq_out = i_rec_data;
                o_sram_dq_oe  = 1'b1;
                o_sram_we_n   = ~i_rec_valid;
            end
            StPlay, StPlayPause: begin
                o_sram_addr = i_play_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/audio_ctrl.sv
// audio_ctrl: key-driven record/playback sequencer and SRAM arbiter.
// Ports:
//   i_clk, i_rst_n        - clock; synchronous reset, active HIGH despite the name
//   i_key_*               - one-cycle key pulses (priority stop > pause > record > play)
//   i_rec_*               - recorder write address/data/strobe
//   i_play_addr/i_play_rd - DSP read request
//   i_sram_dq             - SRAM read data, forwarded on o_play_data
//   o_rec_*/o_dsp_*       - registered one-cycle engine command pulses
//   o_sram_*              - SRAM pin controls
//   o_end_addr/o_has_data - last recorded address / recording present
//   o_state               - current state encoding
// Macro AUDIO_CTRL_LOOP_PLAY_EN: playback end restarts the DSP instead of going idle.
module audio_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]  MAX_ADDR = ADDR_W'(MAX_ADDR_DEF)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_key_record,
    input  logic              i_key_play,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [DATA_W-1:0] i_rec_data,
    input  logic              i_rec_valid,
    input  logic [ADDR_W-1:0] i_play_addr,
    input  logic              i_play_rd,
    input  logic [DATA_W-1:0] i_sram_dq,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_dsp_start,
    output logic              o_dsp_pause,
    output logic              o_dsp_stop,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we_n,
    output logic [DATA_W-1:0] o_sram_dq_out,
    output logic              o_sram_dq_oe,
    output logic [DATA_W-1:0] o_play_data,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic              o_has_data,
    output logic [2:0]        o_state
);

    state_t            r_state, w_state_d;
    cmd_t              r_rec_cmd, w_rec_cmd_d;
    cmd_t              r_dsp_cmd, w_dsp_cmd_d;
    logic [ADDR_W-1:0] r_end_addr, w_end_addr_d;
    logic              r_has_data, w_has_data_d;
    logic              r_restart, w_restart_d;  // loop mode: issue dsp start next cycle

    logic w_key_stop, w_key_pause, w_key_rec, w_key_play;
    logic w_rec_full, w_play_end;

    // Only the highest-priority key of a cycle is allowed to act.
    assign w_key_stop  = i_key_stop;
    assign w_key_pause = ~i_key_stop & i_key_pause;
    assign w_key_rec   = ~i_key_stop & ~i_key_pause & i_key_record;
    assign w_key_play  = ~i_key_stop & ~i_key_pause & ~i_key_record & i_key_play;

    assign w_rec_full = (r_state == StRec) && i_rec_valid && (i_rec_addr == MAX_ADDR);
    assign w_play_end = (r_state == StPlay) && i_play_rd && (i_play_addr == r_end_addr);

    always_comb begin
        w_state_d    = r_state;
        w_rec_cmd_d  = '0;
        w_dsp_cmd_d  = '0;
        w_end_addr_d = r_end_addr;
        w_has_data_d = r_has_data;
        w_restart_d  = 1'b0;

        if (r_state == StRec && i_rec_valid) begin
            w_end_addr_d = i_rec_addr;
            w_has_data_d = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (w_key_rec) begin
                    w_state_d         = StRec;
                    w_rec_cmd_d.start = 1'b1;
                    w_end_addr_d      = '0;
                    w_has_data_d      = 1'b0;
                end else if (w_key_play && r_has_data) begin
                    w_state_d         = StPlay;
                    w_dsp_cmd_d.start = 1'b1;
                end
            end
            StRec: begin
                // A full memory counts as a stop so a coincident user stop gives one pulse.
                if (w_key_stop || w_rec_full) begin
                    w_state_d        = StIdle;
                    w_rec_cmd_d.stop = 1'b1;
                end else if (w_key_pause) begin
                    w_state_d         = StRecPause;
                    w_rec_cmd_d.pause = 1'b1;
                end
            end
            StRecPause: begin
                if (w_key_stop) begin
                    w_state_d        = StIdle;
                    w_rec_cmd_d.stop = 1'b1;
                end else if (w_key_pause || w_key_rec) begin
                    w_state_d         = StRec;
                    w_rec_cmd_d.start = 1'b1;
                end
            end
            StPlay: begin
                if (w_key_stop) begin
                    w_state_d        = StIdle;
                    w_dsp_cmd_d.stop = 1'b1;
                end else if (w_play_end) begin
                    w_dsp_cmd_d.stop = 1'b1;
`ifdef AUDIO_CTRL_LOOP_PLAY_EN
                    w_restart_d      = 1'b1;
`else
                    w_state_d        = StIdle;
`endif
                end else if (w_key_pause) begin
                    w_state_d         = StPlayPause;
                    w_dsp_cmd_d.pause = 1'b1;
                end else if (r_restart) begin
                    w_dsp_cmd_d.start = 1'b1;
                end
            end
            StPlayPause: begin
                if (w_key_stop) begin
                    w_state_d        = StIdle;
                    w_dsp_cmd_d.stop = 1'b1;
                end else if (w_key_pause || w_key_play) begin
                    w_state_d         = StPlay;
                    w_dsp_cmd_d.start = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            r_state    <= StIdle;
            r_rec_cmd  <= '0;
            r_dsp_cmd  <= '0;
            r_end_addr <= '0;
            r_has_data <= 1'b0;
            r_restart  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_rec_cmd  <= w_rec_cmd_d;
            r_dsp_cmd  <= w_dsp_cmd_d;
            r_end_addr <= w_end_addr_d;
            r_has_data <= w_has_data_d;
            r_restart  <= w_restart_d;
        end
    end

    audio_sram_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram_mux (
        .i_state       (r_state),
        .i_rec_addr    (i_rec_addr),
        .i_rec_data    (i_rec_data),
        .i_rec_valid   (i_rec_valid),
        .i_play_addr   (i_play_addr),
        .o_sram_addr   (o_sram_addr),
        .o_sram_we_n   (o_sram_we_n),
        .o_sram_dq_out (o_sram_dq_out),
        .o_sram_dq_oe  (o_sram_dq_oe)
    );

    assign o_rec_start = r_rec_cmd.start;
    assign o_rec_pause = r_rec_cmd.pause;
    assign o_rec_stop  = r_rec_cmd.stop;
    assign o_dsp_start = r_dsp_cmd.start;
    assign o_dsp_pause = r_dsp_cmd.pause;
    assign o_dsp_stop  = r_dsp_cmd.stop;
    assign o_play_data = i_sram_dq;
    assign o_end_addr  = r_end_addr;
    assign o_has_data  = r_has_data;
    assign o_state     = r_state;

endmodule

// File: doc/audio_ctrl.md
Name: audio_ctrl

Overview:
- Top-level sequencer for the lab3 record/playback path: decodes single-cycle key pulses into start/pause/stop commands for the audio recorder and the playback DSP.
- Arbitrates the single external 16-bit SRAM: recorder writes while recording, DSP reads while playing.
- Tracks the last recorded address and ends playback automatically when that address is reached.
- Sits between the key debouncers, recorder, DSP and SRAM pins.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, sample/SRAM data width
MAX_ADDR, 20'hFFFFF, last writable SRAM address; a recording stops automatically after writing it

Ports:
i_clk  in  1  system clock (recorder bclk domain); all logic on rising edge
i_rst_n  in  1  synchronous, active-high reset
i_key_record  in  1  one-cycle pulse: start recording / resume a paused recording
i_key_play  in  1  one-cycle pulse: start playback / resume a paused playback
i_key_pause  in  1  one-cycle pulse: pause/resume toggle
i_key_stop  in  1  one-cycle pulse: stop the active engine
i_rec_addr  in  ADDR_W  recorder write address
i_rec_data  in  DATA_W  recorder sample
i_rec_valid  in  1  recorder write strobe, one cycle per sample
i_play_addr  in  ADDR_W  DSP read address
i_play_rd  in  1  DSP read strobe
i_sram_dq  in  DATA_W  SRAM read data
o_rec_start / o_rec_pause / o_rec_stop  out  1 each  recorder command pulses
o_dsp_start / o_dsp_pause / o_dsp_stop  out  1 each  DSP command pulses
o_sram_addr  out  ADDR_W  SRAM address
o_sram_we_n  out  1  SRAM write enable, active low
o_sram_dq_out  out  DATA_W  SRAM write data
o_sram_dq_oe  out  1  drive enable for the dq bus
o_play_data  out  DATA_W  read data to the DSP (i_sram_dq passed through)
o_end_addr  out  ADDR_W  last recorded address
o_has_data  out  1  a valid recording exists
o_state  out  3  current FSM state encoding

Behaviour:
- States: IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4.
- Reset (any time, including mid-operation):
  - State goes to IDLE; all command pulses are 0.
  - o_sram_we_n=1, o_sram_dq_oe=0, o_sram_addr=0.
  - o_end_addr=0, o_has_data=0.
  - No stop pulse is issued; the engines share the same reset.
- Key priority when several keys pulse in the same cycle: stop > pause > record > play. Only the winning key acts.
- Command pulses are registered: exactly one cycle wide, asserted in the cycle after the key edge, and coincident with the state change.
- Transitions:
  - IDLE + record: go to REC, pulse o_rec_start, clear o_has_data and o_end_addr.
  - IDLE + play with o_has_data=1: go to PLAY, pulse o_dsp_start.
  - IDLE + play with o_has_data=0: ignored.
  - IDLE + pause or stop: ignored.
  - REC + pause: go to REC_PAUSE, pulse o_rec_pause.
  - REC_PAUSE + pause or record: go to REC, pulse o_rec_start.
  - PLAY + pause: go to PLAY_PAUSE, pulse o_dsp_pause.
  - PLAY_PAUSE + pause or play: go to PLAY, pulse o_dsp_start.
  - REC or REC_PAUSE + stop: go to IDLE, pulse o_rec_stop.
  - PLAY or PLAY_PAUSE + stop: go to IDLE, pulse o_dsp_stop.
  - Play key in REC/REC_PAUSE and record key in PLAY/PLAY_PAUSE: ignored (no cross-switching).
- Recording bookkeeping: in REC, each i_rec_valid sets o_end_addr <= i_rec_addr and o_has_data <= 1.
- Recording full: i_rec_valid with i_rec_addr==MAX_ADDR gives a normal write, then next cycle pulses o_rec_stop and goes to IDLE; o_end_addr=MAX_ADDR.
- Playback end: in PLAY, i_play_rd with i_play_addr==o_end_addr gives a normal read, then next cycle pulses o_dsp_stop and goes to IDLE. A user stop in that same cycle produces one stop pulse only.
- SRAM mux (combinational from the registered state):
  - REC: addr=i_rec_addr, dq_out=i_rec_data, dq_oe=1, we_n=~i_rec_valid.
  - PLAY or PLAY_PAUSE: addr=i_play_addr, dq_oe=0, we_n=1.
  - All other states: addr=0, dq_oe=0, we_n=1.
- i_rec_valid outside REC is ignored: no write, no bookkeeping update.
- o_play_data = i_sram_dq at all times.

Optional Feature:
- Macro: AUDIO_CTRL_LOOP_PLAY_EN.
- Defined: on the playback-end condition, stay in PLAY and pulse o_dsp_stop, then o_dsp_start on the following cycle, so the DSP restarts from address 0. Only the stop key leaves PLAY.
- Undefined: playback end returns to IDLE as described in Behaviour.

Decomposition:
- Package audio_pkg holds:
  - the state typedef (3-bit enum: IDLE, REC, REC_PAUSE, PLAY, PLAY_PAUSE);
  - the ADDR_W/DATA_W defaults and the MAX_ADDR constant;
  - the command-pulse struct {start, pause, stop}.
- One sub-module, audio_sram_mux: the combinational SRAM port mux selected by state. The FSM and bookkeeping stay in audio_ctrl.

Test Plan:
- Reset then record: pulse record, feed 5 writes at addr 0..4, pulse stop. Expect o_rec_start one cycle after the key, we_n low in each valid cycle, o_rec_stop, o_end_addr=4, o_has_data=1, state IDLE.
- Pause/resume: during REC pulse pause. Expect o_rec_pause, state 2, and a valid write during pause gives no SRAM write. Pulse record: expect o_rec_start, state 1.
- Playback end: with end_addr=4, pulse play and issue reads at addr 0..4. Expect o_dsp_start, dq_oe=0, o_dsp_stop one cycle after the addr-4 read, state IDLE; with LOOP_PLAY_EN, expect stop then start on consecutive cycles.
- Guards: play with o_has_data=0 gives no pulse; record during PLAY is ignored; stop+pause in the same cycle during REC gives only o_rec_stop.
- Full memory: MAX_ADDR=7, write addr 0..7. Expect an automatic o_rec_stop after the addr-7 write, o_end_addr=7.
- Reset mid-REC: assert i_rst_n for 1 cycle. Expect state 0, we_n=1, o_has_data=0, and no stop pulse.
